// File: rtl/reg_snapshot_checker_if.sv
// rtl/reg_snapshot_checker_if.sv - run control, register-file read port and result signals of reg_snapshot_checker
interface reg_snapshot_checker_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_CH  = 8,
  parameter int DELAY_W = 16
);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     start;
  logic                     abort;
  logic [DELAY_W-1:0]       delay;
  logic [NUM_CH*ADDR_W-1:0] sel_list;
  logic [NUM_CH*DATA_W-1:0] exp_list;
  logic [NUM_CH-1:0]        chk_mask;
  logic [ADDR_W-1:0]        rf_addr;
  logic [DATA_W-1:0]        rf_data;
  logic                     busy;
  logic                     dump_valid;
  logic [IDX_W-1:0]         dump_idx;
  logic [DATA_W-1:0]        dump_data;
  logic                     done;
  logic                     pass;
  logic [CNT_W-1:0]         fail_count;
  logic [IDX_W-1:0]         first_fail_idx;

  modport slave (
    input  start, abort, delay, sel_list, exp_list, chk_mask, rf_data,
    output rf_addr, busy, dump_valid, dump_idx, dump_data, done, pass,
           fail_count, first_fail_idx
  );

  modport master (
    output start, abort, delay, sel_list, exp_list, chk_mask, rf_data,
    input  rf_addr, busy, dump_valid, dump_idx, dump_data, done, pass,
           fail_count, first_fail_idx
  );
endinterface

// File: rtl/reg_snapshot_checker.sv
// rtl/reg_snapshot_checker.sv - register-file snapshot: settle, read each channel, dump and compare
module reg_snapshot_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_CH  = 8,
  parameter int DELAY_W = 16
) (
  input logic                   Clk,
  input logic                   Rst_n,
  reg_snapshot_checker_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, WAIT, ADDR, CMP, DONE} state_t;

  state_t                   state;
  logic [DELAY_W-1:0]       delayCnt;
  logic [IDX_W-1:0]         chIdx;
  logic [NUM_CH*ADDR_W-1:0] selLat;
  logic [NUM_CH*DATA_W-1:0] expLat;
  logic [NUM_CH-1:0]        maskLat;
  logic                     chMiss;

  assign chMiss = maskLat[chIdx] && (bus.rf_data != expLat[chIdx*DATA_W +: DATA_W]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state              <= IDLE;
      delayCnt           <= '0;
      chIdx              <= '0;
      selLat             <= '0;
      expLat             <= '0;
      maskLat            <= '0;
      bus.rf_addr        <= '0;
      bus.busy           <= 1'b0;
      bus.dump_valid     <= 1'b0;
      bus.dump_idx       <= '0;
      bus.dump_data      <= '0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.fail_count     <= '0;
      bus.first_fail_idx <= '0;
    end else begin
      bus.dump_valid <= 1'b0;
      bus.done       <= 1'b0;
      // abort wins over everything, including a completing CMP or a start
      if (state != IDLE && bus.abort) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
        bus.pass <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              selLat             <= bus.sel_list;
              expLat             <= bus.exp_list;
              maskLat            <= bus.chk_mask;
              delayCnt           <= bus.delay;
              chIdx              <= '0;
              bus.fail_count     <= '0;
              bus.first_fail_idx <= '0;
              bus.pass           <= 1'b0;
              bus.busy           <= 1'b1;
              state              <= (bus.delay != '0) ? WAIT : ADDR;
            end
          end
          WAIT: begin
            // counts down to 1 so an all-ones delay never wraps
            if (delayCnt == DELAY_W'(1)) state <= ADDR;
            else                         delayCnt <= delayCnt - DELAY_W'(1);
          end
          ADDR: begin
            bus.rf_addr <= selLat[chIdx*ADDR_W +: ADDR_W];
            state       <= CMP;
          end
          CMP: begin
            bus.dump_valid <= 1'b1;
            bus.dump_idx   <= chIdx;
            bus.dump_data  <= bus.rf_data;
            if (chMiss) begin
              bus.fail_count <= bus.fail_count + CNT_W'(1);
              if (bus.fail_count == '0) bus.first_fail_idx <= chIdx;
            end
            if (chIdx == LAST_CH) begin
              bus.done <= 1'b1;
              bus.pass <= !chMiss && (bus.fail_count == '0);
              state    <= DONE;
            end else begin
              chIdx <= chIdx + IDX_W'(1);
              state <= ADDR;
            end
          end
          DONE: begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reg_snapshot_checker.sv
// tb/tb_reg_snapshot_checker.sv - self-checking bench for reg_snapshot_checker
module tb_reg_snapshot_checker;
  localparam int N = 8;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  reg_snapshot_checker_if bus();
  reg_snapshot_checker dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  logic [31:0] regs [32];
  assign bus.rf_data = regs[bus.rf_addr];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           dly;
    logic [39:0]  sel;
    logic [255:0] ex;
    logic [7:0]   msk;
    int           efc;
    int           eff;
    bit           epass;
    int           injectAt;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: every masked-in channel whose register differs from its expectation counts.
  function automatic void model(input logic [39:0] sel, input logic [255:0] ex, input logic [7:0] msk,
                                output int fc, output int ff, output bit ps);
    fc = 0;
    ff = 0;
    for (int i = 0; i < N; i++) begin
      if (msk[i] && regs[sel[i*5 +: 5]] != ex[i*32 +: 32]) begin
        if (fc == 0) ff = i;
        fc++;
      end
    end
    ps = (fc == 0);
  endfunction

  task automatic start_run(input int dly, input logic [39:0] sel, input logic [255:0] ex, input logic [7:0] msk);
    @(negedge Clk);
    bus.delay    = 16'(dly);
    bus.sel_list = sel;
    bus.exp_list = ex;
    bus.chk_mask = msk;
    bus.start    = 1'b1;
    @(posedge Clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  k;
    int  nd;
    int  doneAt;
    bit  busyOk;
    start_run(v.dly, v.sel, v.ex, v.msk);
    k = 0; nd = 0; doneAt = -1; busyOk = 1;
    while (doneAt < 0 && k < v.dly + 2*N + 20) begin
      @(posedge Clk);
      #1;
      k++;
      if (!bus.busy) busyOk = 0;
      if (bus.dump_valid) begin
        if (nd < N) begin
          chk($sformatf("%s dump_idx[%0d]", nm, nd), bus.dump_idx, nd);
          chk($sformatf("%s dump_data[%0d]", nm, nd), bus.dump_data, regs[v.sel[nd*5 +: 5]]);
          chk($sformatf("%s dump_time[%0d]", nm, nd), k, v.dly + 2*nd + 2);
        end
        nd++;
      end
      if (bus.done) doneAt = k;
      if (v.injectAt > 0 && k == v.injectAt) begin
        bus.start    = 1'b1;
        bus.delay    = '0;
        bus.sel_list = ~v.sel;
        bus.exp_list = ~v.ex;
        bus.chk_mask = ~v.msk;
      end else if (v.injectAt > 0 && k == v.injectAt + 1) begin
        bus.start    = 1'b0;
        bus.delay    = 16'(v.dly);
        bus.sel_list = v.sel;
        bus.exp_list = v.ex;
        bus.chk_mask = v.msk;
      end
    end
    chk({nm, " done_time"}, doneAt, v.dly + 2*N);
    chk({nm, " dump_count"}, nd, N);
    chk({nm, " busy_hold"}, busyOk, 1);
    chk({nm, " fail_count"}, bus.fail_count, v.efc);
    chk({nm, " first_fail_idx"}, bus.first_fail_idx, v.eff);
    chk({nm, " pass"}, bus.pass, v.epass);
    @(posedge Clk);
    #1;
    chk({nm, " busy_after"}, bus.busy, 0);
    chk({nm, " done_once"}, bus.done, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          selTab [8];
    logic [39:0] baseSel;
    logic [255:0] baseEx;
    vec_t        v;
    int          k;
    int          nd;
    bit          sawDone;

    selTab = '{16, 17, 18, 8, 9, 10, 11, 12};
    for (int i = 0; i < 32; i++) regs[i] = 32'(10 * i);
    for (int i = 0; i < N; i++) begin
      baseSel[i*5 +: 5]  = 5'(selTab[i]);
      baseEx[i*32 +: 32] = 32'(10 * selTab[i]);
    end

    vecs[0] = '{0,   baseSel, baseEx, 8'hFF, 0, 0, 1'b1, 0};
    vecs[1] = vecs[0];
    vecs[1].ex[3*32 +: 32] = 32'd81;
    vecs[1].ex[6*32 +: 32] = 32'd0;
    vecs[1].efc = 2; vecs[1].eff = 3; vecs[1].epass = 1'b0;
    vecs[2] = vecs[1];
    vecs[2].msk = 8'hF7;
    vecs[2].efc = 1; vecs[2].eff = 6;
    vecs[3] = vecs[1];
    vecs[3].msk = 8'h00;
    vecs[3].efc = 0; vecs[3].eff = 0; vecs[3].epass = 1'b1;
    vecs[4] = vecs[0];
    vecs[4].dly = 300; vecs[4].injectAt = 50;

    bus.start = 0; bus.abort = 0; bus.delay = '0;
    bus.sel_list = '0; bus.exp_list = '0; bus.chk_mask = '0;
    repeat (3) @(negedge Clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset pass", bus.pass, 0);
    chk("reset rf_addr", bus.rf_addr, 0);
    chk("reset dump_valid", bus.dump_valid, 0);
    chk("reset fail_count", bus.fail_count, 0);
    Rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort during CMP of channel 2; channel 0 mismatches so partial counts are visible
    v = vecs[0];
    v.ex[0 +: 32] = 32'd1;
    start_run(v.dly, v.sel, v.ex, v.msk);
    k = 0; nd = 0; sawDone = 0;
    while (k < 5) begin
      @(posedge Clk);
      #1;
      k++;
      if (bus.dump_valid) nd++;
      if (bus.done) sawDone = 1;
    end
    bus.abort = 1'b1;
    @(posedge Clk);
    #1;
    bus.abort = 1'b0;
    if (bus.dump_valid) nd++;
    chk("abort busy", bus.busy, 0);
    chk("abort dump_valid", bus.dump_valid, 0);
    chk("abort pass", bus.pass, 0);
    chk("abort fail_count", bus.fail_count, 1);
    chk("abort first_fail_idx", bus.first_fail_idx, 0);
    repeat (12) begin
      @(posedge Clk);
      #1;
      if (bus.done) sawDone = 1;
      if (bus.dump_valid) nd++;
    end
    chk("abort no_done", sawDone, 0);
    chk("abort dump_count", nd, 2);
    run_vec(vecs[0], "after_abort");

    // asynchronous reset while in CMP of channel 1
    start_run(0, baseSel, baseEx, 8'hFF);
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    chk("pre_reset rf_addr", bus.rf_addr, 17);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_reset busy", bus.busy, 0);
    chk("async_reset rf_addr", bus.rf_addr, 0);
    chk("async_reset dump_data", bus.dump_data, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    run_vec(vecs[1], "after_reset");

    // randomized runs against the reference model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom_range(0, 3) == 0 ? 32'(i) : $urandom;
      v.dly = $urandom_range(0, 6);
      v.msk = 8'($urandom);
      v.injectAt = 0;
      for (int i = 0; i < N; i++) begin
        v.sel[i*5 +: 5] = 5'($urandom);
        v.ex[i*32 +: 32] = $urandom_range(0, 1) == 0 ? regs[v.sel[i*5 +: 5]] : $urandom;
      end
      model(v.sel, v.ex, v.msk, v.efc, v.eff, v.epass);
      run_vec(v, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_snapshot_checker.md
Name: reg_snapshot_checker

Overview:
- Parametrised, synthesizable register-file snapshot and check unit for the single-cycle CPU.
- After a programmable settle delay, it reads a list of NUM_CH register indices through a dedicated register-file read port, one at a time.
- It streams each value out and compares it against expected values.
- It reports pass/fail, the failure count and the first failing channel. It replaces manual end-of-run register dumps in regression benches and FPGA bring-up.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- NUM_CH, 8, number of channels (registers) checked per run; must be >= 1.
- DELAY_W, 16, width of the settle-delay counter.
- CNT_W, $clog2(NUM_CH+1), width of fail_count (derived; do not override).
- IDX_W, $clog2(NUM_CH) (minimum 1), width of channel-index outputs (derived).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  cancel an active run; returns to IDLE with no done pulse.
- delay  in  DELAY_W  settle cycles before the first read; sampled on start.
- sel_list  in  NUM_CH*ADDR_W  channel i register index at bits [i*ADDR_W +: ADDR_W]; sampled on start.
- exp_list  in  NUM_CH*DATA_W  channel i expected value; sampled on start.
- chk_mask  in  NUM_CH  1 = compare channel i, 0 = dump only; sampled on start.
- rf_addr  out  ADDR_W  register-file read address (registered).
- rf_data  in  DATA_W  combinational register-file read data for rf_addr.
- busy  out  1  high from the start-accept edge until DONE exits.
- dump_valid  out  1  one-cycle strobe per channel read.
- dump_idx  out  IDX_W  channel index for dump_valid.
- dump_data  out  DATA_W  value read for dump_idx.
- done  out  1  one-cycle completion pulse.
- pass  out  1  1 when no compared channel mismatched; valid from done, held until next start.
- fail_count  out  CNT_W  number of mismatching compared channels.
- first_fail_idx  out  IDX_W  lowest mismatching channel index; 0 if none.

Behaviour:
- Reset (async, Rst_n=0): state IDLE; all outputs 0, including pass, rf_addr and counters. Latched lists are cleared to 0.
- States: IDLE, WAIT, ADDR, CMP, DONE.
- IDLE:
  - start=1 at edge E0: latch delay, sel_list, exp_list and chk_mask; clear fail_count, first_fail_idx and pass; set busy=1.
  - Go to WAIT if delay>0, otherwise go directly to ADDR (ch 0).
- WAIT: counts `delay` cycles, then goes to ADDR. ADDR for ch i is entered at edge E0+delay+2i.
- ADDR: rf_addr <= sel[i]; next state CMP.
- CMP: at the exiting edge:
  - Sample rf_data into dump_data; pulse dump_valid with dump_idx=i.
  - If chk_mask[i] and rf_data != exp[i]: increment fail_count; if this is the first failure, record i in first_fail_idx.
  - If i = NUM_CH-1, go to DONE; otherwise go to ADDR (i+1).
- DONE:
  - Entered at edge E0+delay+2*NUM_CH, the same edge as the last dump_valid.
  - done=1 for exactly that one cycle; pass = (fail_count==0) is registered at the same edge.
  - Next edge goes to IDLE with busy=0.
- Totals: run latency from start to done = delay + 2*NUM_CH cycles. A minimum-latency run (delay=0, NUM_CH=1) gives done 2 cycles after start.
- start while busy is ignored, including in DONE; latched inputs do not change.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE, busy=0, no done pulse, no dump_valid in that cycle.
  - pass is forced to 0; fail_count and first_fail_idx keep partial values.
  - abort takes priority over start when both are high in the same cycle.
- A delay counter of all-ones must not wrap; WAIT lasts exactly 2^DELAY_W-1 cycles.
- Masked channels are still read and dumped but never counted.
- If every channel is masked, pass=1.
- rf_addr holds its last value outside ADDR/CMP.
- Reset asserted mid-run takes effect immediately (asynchronously) and returns all outputs to their reset values.

Test Plan:
- NUM_CH=8, delay=0, sel={16,17,18,8,9,10,11,12}, model registers hold 10*index, expected values match, mask=8'hFF -> 8 dump_valid pulses on alternate cycles, dump_idx 0..7, dump_data 160,170,180,80,90,100,110,120; done at E0+16; pass=1; fail_count=0.
- Same run but exp[3]=81 and exp[6]=0 -> fail_count=2, first_fail_idx=3, pass=0.
- Same mismatches with mask bit 3 cleared -> fail_count=1, first_fail_idx=6; channel 3 still dumped with value 80.
- delay=300 -> first dump_valid at E0+302, done at E0+316, busy high throughout; a start pulse at E0+50 is ignored and the latched lists are unchanged.
- abort at E0+5 with delay=0 -> idle at E0+6, busy=0, done never asserted, pass=0, only channels 0-1 dumped. A subsequent start then runs to completion normally.
- Rst_n low mid-CMP -> all outputs 0 immediately, asynchronously; after release, start works from IDLE.
